// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sequencer and its counter core.
package counter_pkg;

    // Default counter width
    localparam int CNT_W = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/counter_core.sv
// W-bit binary up-counter built from per-bit flops with AND-chain toggle logic.
// clr_i forces zero, en_i increments by one, otherwise the value is held.
module counter_core
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] toggle;

    // Bit i toggles when counting is enabled and every lower bit is one
    assign toggle[0] = en_i;
    for (genvar i = 1; i < W; i++) begin : g_toggle
        assign toggle[i] = en_i & (&q_q[i-1:0]);
    end

    // Next value: clear has priority over increment
    always_comb begin
        q_d = q_q ^ toggle;
        if (clr_i) begin
            q_d = '0;
        end
    end

    // One flop per bit, each with its own asynchronous reset leg
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic bit_q;

        // Per-bit storage cell
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= q_d[i];
            end
        end

        assign q_q[i] = bit_q;
    end

    assign q_o = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for the W-bit up-counter: accepts a terminal-count configuration
// over valid/ready, runs the counter one-shot or auto-reload with start/stop/
// pause control, and reports terminal-count ticks and completion.
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_limit,
    input  logic         cfg_autoreload,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] limit_q;
    logic [W-1:0] limit_d;
    logic         auto_q;
    logic         auto_d;
    logic [W-1:0] cnt;
    logic         cnt_clr;
    logic         cnt_en;
    logic         xfer;
    logic         terminal;

    // Configuration is only accepted while no run is in progress
    assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
    assign xfer      = cfg_valid && cfg_ready;

    // The config registers load on the very edge that enters RUN, so a
    // transfer coinciding with start already governs the first RUN cycle.
    assign limit_d = xfer ? cfg_limit      : limit_q;
    assign auto_d  = xfer ? cfg_autoreload : auto_q;

    assign terminal = (cnt == limit_q);

    // Next-state and counter control; priority stop > start > terminal > pause > increment
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (terminal && auto_q) begin
                    cnt_clr = 1'b1;
                end else if (terminal) begin
                    state_d = DONE;
                end else if (pause) begin
                    state_d = HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State and configuration registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            limit_q <= '1;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            auto_q  <= auto_d;
        end
    end

    counter_core #(
        .W(W)
    ) u_core (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .q_o   (cnt)
    );

    assign count = cnt;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign tick  = (state_q == RUN) && terminal;
    assign done  = (state_q == DONE);

endmodule
